// File: rtl/lzss_token_gen.sv
// LZSS token generator: follows the priority encoder, tracks match length and
// emits literal or (offset, length) tokens over a valid/ready handshake.
module lzss_token_gen #(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned SYM_W     = 8,
   parameter int unsigned MIN_MATCH = 3,
   parameter int unsigned MAX_LEN   = 8,
   parameter int unsigned OFF_W     = $clog2(DEPTH*WIDTH+1),
   parameter int unsigned LEN_W     = $clog2(MAX_LEN+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SYM_W-1:0] in_symbol,
   input  logic             in_last,
   input  logic             symbol_match,
   input  logic [DEPTH-1:0] row,
   input  logic [WIDTH-1:0] col,
   input  logic             cont_hit,
   output logic             tok_valid,
   input  logic             tok_ready,
   output logic             tok_is_pair,
   output logic [SYM_W-1:0] tok_literal,
   output logic [OFF_W-1:0] tok_offset,
   output logic [LEN_W-1:0] tok_length,
   output logic             tok_last
);

   typedef enum logic [1:0] {IDLE, MATCH, EMIT, FLUSH} state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [OFF_W-1:0] off_q, off_d;
   logic [LEN_W-1:0] fidx_q, fidx_d;
   logic             last_q, last_d;
   logic [SYM_W-1:0] sym_buf_q [MIN_MATCH];
   logic [SYM_W-1:0] sym_buf_d [MIN_MATCH];

   logic             tok_valid_d;
   logic             tok_is_pair_d;
   logic [SYM_W-1:0] tok_literal_d;
   logic [OFF_W-1:0] tok_offset_d;
   logic [LEN_W-1:0] tok_length_d;
   logic             tok_last_d;

   logic             close;
   logic             close_last;
   logic [OFF_W-1:0] match_off;
   logic [SYM_W-1:0] flush_sym;

   assign match_off = OFF_W'(row) * OFF_W'(WIDTH) + OFF_W'(col);

   // Buffered short-match symbol selected by the flush index
   always_comb begin
      flush_sym = '0;
      for (int i = 0; i < int'(MIN_MATCH); i++) begin
         if (LEN_W'(i) == fidx_q) flush_sym = sym_buf_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         len_q       <= '0;
         off_q       <= '0;
         fidx_q      <= '0;
         last_q      <= 1'b0;
         sym_buf_q   <= '{default: '0};
         tok_valid   <= 1'b0;
         tok_is_pair <= 1'b0;
         tok_literal <= '0;
         tok_offset  <= '0;
         tok_length  <= '0;
         tok_last    <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         off_q       <= off_d;
         fidx_q      <= fidx_d;
         last_q      <= last_d;
         sym_buf_q   <= sym_buf_d;
         tok_valid   <= tok_valid_d;
         tok_is_pair <= tok_is_pair_d;
         tok_literal <= tok_literal_d;
         tok_offset  <= tok_offset_d;
         tok_length  <= tok_length_d;
         tok_last    <= tok_last_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      off_d         = off_q;
      fidx_d        = fidx_q;
      last_d        = last_q;
      sym_buf_d     = sym_buf_q;
      tok_valid_d   = tok_valid;
      tok_is_pair_d = tok_is_pair;
      tok_literal_d = tok_literal;
      tok_offset_d  = tok_offset;
      tok_length_d  = tok_length;
      tok_last_d    = tok_last;
      in_ready      = 1'b0;
      close         = 1'b0;
      close_last    = 1'b0;

      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (!symbol_match) begin
                  tok_valid_d   = 1'b1;
                  tok_is_pair_d = 1'b0;
                  tok_literal_d = in_symbol;
                  tok_offset_d  = '0;
                  tok_length_d  = '0;
                  tok_last_d    = in_last;
                  state_d       = EMIT;
               end else begin
                  off_d        = match_off;
                  len_d        = LEN_W'(1);
                  sym_buf_d[0] = in_symbol;
                  last_d       = 1'b0;
                  state_d      = MATCH;
                  close        = in_last;
                  close_last   = in_last;
               end
            end
         end
         MATCH: begin
            in_ready = cont_hit;
            if (in_valid) begin
               if (cont_hit) begin
                  for (int i = 0; i < int'(MIN_MATCH); i++) begin
                     if (LEN_W'(i) == len_q) sym_buf_d[i] = in_symbol;
                  end
                  len_d      = len_q + LEN_W'(1);
                  close      = (len_d == LEN_W'(MAX_LEN)) || in_last;
                  close_last = in_last;
               end else begin
                  // Breaking symbol stays on the input for a fresh IDLE decision
                  close = 1'b1;
               end
            end
         end
         EMIT: begin
            if (tok_ready) begin
               tok_valid_d   = 1'b0;
               tok_is_pair_d = 1'b0;
               tok_literal_d = '0;
               tok_offset_d  = '0;
               tok_length_d  = '0;
               tok_last_d    = 1'b0;
               len_d         = '0;
               state_d       = IDLE;
            end
         end
         FLUSH: begin
            if (tok_ready) begin
               if (fidx_q < len_q) begin
                  tok_valid_d   = 1'b1;
                  tok_literal_d = flush_sym;
                  tok_last_d    = last_q && (fidx_q == len_q - LEN_W'(1));
                  fidx_d        = fidx_q + LEN_W'(1);
               end else begin
                  tok_valid_d   = 1'b0;
                  tok_literal_d = '0;
                  tok_last_d    = 1'b0;
                  len_d         = '0;
                  fidx_d        = '0;
                  last_d        = 1'b0;
                  state_d       = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Close: long matches become a pair, short ones replay as literals
      if (close) begin
         last_d      = close_last;
         tok_valid_d = 1'b1;
         if (len_d >= LEN_W'(MIN_MATCH)) begin
            tok_is_pair_d = 1'b1;
            tok_literal_d = '0;
            tok_offset_d  = off_d;
            tok_length_d  = len_d;
            tok_last_d    = close_last;
            state_d       = EMIT;
         end else begin
            tok_is_pair_d = 1'b0;
            tok_literal_d = sym_buf_d[0];
            tok_offset_d  = '0;
            tok_length_d  = '0;
            tok_last_d    = close_last && (len_d == LEN_W'(1));
            fidx_d        = LEN_W'(1);
            state_d       = FLUSH;
         end
      end
   end

endmodule
